// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// The ESR layout depends on module parameters, so only the fixed pieces are
// kept here:
//   sync  : ESR = zext(EStatus)
//   async : ESR = flag bit at STATUS_W, source index in the low bits
//   ESR[N-1] is a sticky double-fault bit, set by ESync while in HANDLER.
package exc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } exc_state_t;

  // EDataSel read-mux codes
  localparam logic [1:0] SEL_ELR  = 2'b00;
  localparam logic [1:0] SEL_ESR  = 2'b01;
  localparam logic [1:0] SEL_ERR  = 2'b10;
  localparam logic [1:0] SEL_PEND = 2'b11;

  // Number of ESR bits below the top bit that hold the double-fault flag
  localparam int ESR_DFAULT_FROM_MSB = 0;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: bit 0 of the request vector has the highest priority.
module exc_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so that the lowest set index is the last one written
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller for the single-cycle LEGv8 datapath.
// It arbitrates one synchronous fault and NUM_SRC edge-triggered async
// requests, captures ELR/ESR/ERR on entry, and serves ERET and register reads.
// Optional feature: define EXC_VECTORED_EN to give each async source its own
// handler vector. Without it, every exception enters at VEC_BASE.
//
// state   | meaning
// IDLE    | normal execution; may take sync fault or lowest pending source
// HANDLER | inside handler; no nesting, waiting for ERet
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int           N          = 64,
  parameter int           NUM_SRC    = 4,
  parameter int           STATUS_W   = 4,
  parameter logic [N-1:0] VEC_BASE   = 'hD8,
  parameter logic [N-1:0] VEC_STRIDE = 'h20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ESync,
  input  logic [STATUS_W-1:0] EStatus,
  input  logic [NUM_SRC-1:0]  exc_req,
  input  logic                ERet,
  input  logic [N-1:0]        NextPC_X,
  input  logic [N-1:0]        imem_addr_X,
  input  logic [N-1:0]        ALUBranch_X,
  input  logic [1:0]          EDataSel,
  output logic                EProc_X,
  output logic [N-1:0]        EVAddr_X,
  output logic [N-1:0]        PCBranch_X,
  output logic [N-1:0]        readData_X,
  output logic                ExcAck
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [N-1:0] ONE            = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ESR_ASYNC_FLAG = ONE << STATUS_W;

`ifdef EXC_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  exc_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] req_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] pend_clr;
  logic [N-1:0]       elr_q, elr_d;
  logic [N-1:0]       esr_q, esr_d;
  logic [N-1:0]       err_q, err_d;
  logic               ack_q;
  logic               pend_valid;
  logic [IDX_W-1:0]   pend_idx;
  logic [N-1:0]       pend_idx_ext;
  logic               take_sync;
  logic               take_async;

  exc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req_i   (pending_q),
    .valid_o (pend_valid),
    .idx_o   (pend_idx)
  );

  assign pend_idx_ext = {{(N-IDX_W){1'b0}}, pend_idx};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one take per IDLE visit, ERet is the only way out
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ESync || pend_valid) state_d = HANDLER;
      HANDLER: if (ERet)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Take decode: a sync fault always beats pending async sources
  always_comb begin
    take_sync  = 1'b0;
    take_async = 1'b0;
    if (state_q == IDLE) begin
      take_sync  = ESync;
      take_async = ~ESync & pend_valid;
    end
  end

  assign EProc_X = take_sync | take_async;

  // Capture-register and pending next values; a new edge beats a clear of the same bit
  always_comb begin
    elr_d    = elr_q;
    err_d    = err_q;
    esr_d    = esr_q;
    pend_clr = '0;
    if (EProc_X) begin
      elr_d = NextPC_X;
      err_d = imem_addr_X;
      if (take_sync) begin
        esr_d = {{(N-STATUS_W){1'b0}}, EStatus};
      end else begin
        esr_d    = ESR_ASYNC_FLAG | pend_idx_ext;
        pend_clr = NUM_SRC'(1) << pend_idx;
      end
    end else if (state_q == HANDLER && ESync) begin
      esr_d[N-1-ESR_DFAULT_FROM_MSB] = 1'b1;
    end
    pending_d = (pending_q & ~pend_clr) | (exc_req & ~req_prev_q);
  end

  // Capture registers, pending flags, edge history and entry acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr_q      <= '0;
      esr_q      <= '0;
      err_q      <= '0;
      pending_q  <= '0;
      req_prev_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
      req_prev_q <= exc_req;
      ack_q      <= EProc_X;
    end
  end

  assign ExcAck = ack_q;

  // Handler entry address; only meaningful while EProc_X is high
  assign EVAddr_X = (VECTORED && !ESync)
                  ? VEC_BASE + (pend_idx_ext + ONE) * VEC_STRIDE
                  : VEC_BASE;

  assign PCBranch_X = (state_q == HANDLER && ERet) ? elr_q : ALUBranch_X;

  // Read mux for MRS-style accesses
  always_comb begin
    readData_X = '0;
    case (EDataSel)
      SEL_ELR:  readData_X = elr_q;
      SEL_ESR:  readData_X = esr_q;
      SEL_ERR:  readData_X = err_q;
      SEL_PEND: readData_X = {{(N-NUM_SRC){1'b0}}, pending_q};
      default:  readData_X = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the exception rules.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ESync;
  logic [3:0]  EStatus;
  logic [3:0]  exc_req;
  logic        ERet;
  logic [63:0] NextPC_X;
  logic [63:0] imem_addr_X;
  logic [63:0] ALUBranch_X;
  logic [1:0]  EDataSel;
  logic        EProc_X;
  logic [63:0] EVAddr_X;
  logic [63:0] PCBranch_X;
  logic [63:0] readData_X;
  logic        ExcAck;

  exception_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ESync       (ESync),
    .EStatus     (EStatus),
    .exc_req     (exc_req),
    .ERet        (ERet),
    .NextPC_X    (NextPC_X),
    .imem_addr_X (imem_addr_X),
    .ALUBranch_X (ALUBranch_X),
    .EDataSel    (EDataSel),
    .EProc_X     (EProc_X),
    .EVAddr_X    (EVAddr_X),
    .PCBranch_X  (PCBranch_X),
    .readData_X  (readData_X),
    .ExcAck      (ExcAck)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int take_cnt = 0;

  // reference model state
  bit        m_inh;
  bit [3:0]  m_pend, m_prev;
  bit [63:0] m_elr, m_esr, m_err;
  bit        m_ack;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] exp_vec(input logic sync, input int src);
`ifdef EXC_VECTORED_EN
    if (sync) return 64'hD8;
    return 64'hD8 + 64'(src + 1) * 64'h20;
`else
    return 64'hD8;
`endif
  endfunction

  task automatic model_reset();
    m_inh = 0; m_pend = 0; m_prev = 0;
    m_elr = 0; m_esr = 0; m_err = 0; m_ack = 0;
  endtask

  task automatic idle_inputs();
    ESync = 0; EStatus = 0; exc_req = 0; ERet = 0;
    NextPC_X = 0; imem_addr_X = 0; ALUBranch_X = 0; EDataSel = 0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance model, check ExcAck
  task automatic step();
    int src;
    bit take;
    logic [63:0] exp_rd;
    #3;
    src  = lowest(m_pend);
    take = !m_inh && (ESync || src >= 0);
    check("eproc", EProc_X, 64'(take));
    if (EProc_X) take_cnt++;
    if (take) check("evaddr", EVAddr_X, exp_vec(ESync, src));
    check("pcbranch", PCBranch_X, (m_inh && ERet) ? m_elr : ALUBranch_X);
    case (EDataSel)
      2'd0:    exp_rd = m_elr;
      2'd1:    exp_rd = m_esr;
      2'd2:    exp_rd = m_err;
      default: exp_rd = {60'b0, m_pend};
    endcase
    check("readdata", readData_X, exp_rd);
    m_ack = take;
    if (take) begin
      m_elr = NextPC_X;
      m_err = imem_addr_X;
      if (ESync) m_esr = 64'(EStatus);
      else begin
        m_esr = 64'h10 + 64'(src);
        m_pend[src] = 1'b0;
      end
      m_inh = 1;
    end else if (m_inh) begin
      if (ESync) m_esr[63] = 1'b1;
      if (ERet)  m_inh = 0;
    end
    m_pend = m_pend | (exc_req & ~m_prev);
    m_prev = exc_req;
    @(posedge clk);
    #1;
    check("excack", ExcAck, 64'(m_ack));
  endtask

  task automatic peek(input logic [1:0] sel, input logic [63:0] exp, input string tag);
    EDataSel = sel;
    #1;
    check(tag, readData_X, exp);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_eproc", EProc_X, 0);
    check("rst_ack", ExcAck, 0);
    peek(2'd3, 0, "rst_pend");
    peek(2'd1, 0, "rst_esr");
    reset = 1;
    @(posedge clk);
    #1;

    // T2: synchronous fault entry
    ESync = 1; EStatus = 4'd3; NextPC_X = 64'h104; imem_addr_X = 64'h100; ALUBranch_X = 64'h500;
    #1;
    check("t2_eproc", EProc_X, 1);
    check("t2_evaddr", EVAddr_X, 64'hD8);
    step();
    check("t2_ack", ExcAck, 1);
    idle_inputs();
    peek(2'd0, 64'h104, "t2_elr");
    peek(2'd1, 64'h3, "t2_esr");
    peek(2'd2, 64'h100, "t2_err");
    step();
    check("t2_ack_drop", ExcAck, 0);

    // T4: ERet in HANDLER returns to ELR; ERet in IDLE is ignored
    ERet = 1; ALUBranch_X = 64'h500;
    #1;
    check("t4_eret", PCBranch_X, 64'h104);
    step();
    #1;
    check("t4_idle_eret", PCBranch_X, 64'h500);
    step();
    idle_inputs();

    // T3: two simultaneous async sources, lowest index first
    exc_req = 4'b0110;
    step();
    #1;
    check("t3_take1", EProc_X, 1);
`ifdef EXC_VECTORED_EN
    check("t3_vec1", EVAddr_X, 64'h118);
`endif
    step();
    peek(2'd1, 64'h11, "t3_esr1");
    ERet = 1;
    step();
    ERet = 0;
    #1;
    check("t3_take2", EProc_X, 1);
`ifdef EXC_VECTORED_EN
    check("t3_vec2", EVAddr_X, 64'h138);
`endif
    step();
    peek(2'd1, 64'h12, "t3_esr2");
    ERet = 1;
    step();
    exc_req = 0; ERet = 0;
    step();

    // T5: double fault is sticky and does not redirect; held level takes once
    ESync = 1; EStatus = 4'd5;
    step();
    #1;
    check("t5_no_nest", EProc_X, 0);
    step();
    ESync = 0;
    peek(2'd1, 64'h8000_0000_0000_0005, "t5_dfault");
    ERet = 1;
    step();
    ERet = 0;
    take_cnt = 0;
    exc_req = 4'b1000;
    repeat (10) step();
    check("t5_one_take", 64'(take_cnt), 1);
    ERet = 1;
    step();
    exc_req = 0; ERet = 0;
    repeat (2) step();

    // T6: new edge on bit0 in the same cycle bit0 is taken stays pending
    ESync = 1; EStatus = 4'd1;
    step();
    ESync = 0; exc_req = 4'b0001;
    step();
    exc_req = 0; ERet = 1;
    step();
    exc_req = 4'b0001; ERet = 0;
    #1;
    check("t6_take", EProc_X, 1);
    step();
    peek(2'd3, 64'h1, "t6_pend");

    // T1: reset asserted mid-handler
    idle_inputs();
    ERet = 1; ALUBranch_X = 64'h777;
    #2;
    reset = 0;
    #1;
    check("t1_eproc", EProc_X, 0);
    check("t1_ack", ExcAck, 0);
    check("t1_pcbranch", PCBranch_X, 64'h777);
    peek(2'd0, 0, "t1_elr");
    peek(2'd1, 0, "t1_esr");
    peek(2'd3, 0, "t1_pend");
    reset = 1;
    model_reset();
    ERet = 0;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ESync       = ($urandom_range(0, 7) == 0);
      EStatus     = 4'($urandom);
      if ($urandom_range(0, 3) == 0) exc_req = 4'($urandom);
      ERet        = ($urandom_range(0, 3) == 0);
      NextPC_X    = {$urandom, $urandom};
      imem_addr_X = {$urandom, $urandom};
      ALUBranch_X = {$urandom, $urandom};
      EDataSel    = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
